// File: rtl/ps2_pkg.sv
// Shared PS/2 host constants, the LED command sequencer state encoding and
// the phase-to-command-byte mapping.
package ps2_pkg;

   localparam int unsigned TIMER_W = 24;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [BYTE_W-1:0] CMD_SET_LED  = 8'hED;
   localparam logic [BYTE_W-1:0] CMD_RESET    = 8'hFF;
   localparam logic [BYTE_W-1:0] RSP_ACK      = 8'hFA;
   localparam logic [BYTE_W-1:0] RSP_RESEND   = 8'hFE;
   localparam logic [BYTE_W-1:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [BYTE_W-1:0] RSP_BAT_FAIL = 8'hFC;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_SEND    = 3'd1;
   localparam state_t ST_TXSTART = 3'd2;
   localparam state_t ST_TXDONE  = 3'd3;
   localparam state_t ST_WAITACK = 3'd4;
   localparam state_t ST_WAITBAT = 3'd5;

   typedef logic [1:0] phase_t;
   localparam phase_t PH_SET   = 2'd0;
   localparam phase_t PH_LEDS  = 2'd1;
   localparam phase_t PH_RESET = 2'd2;

   // Byte put on the wire for a given command phase.
   function automatic logic [BYTE_W-1:0] cmd_byte(input phase_t ph, input logic [2:0] leds);
      case (ph)
         PH_SET:  return CMD_SET_LED;
         PH_LEDS: return {5'b0_0000, leds};
         default: return CMD_RESET;
      endcase
   endfunction

endpackage

// File: rtl/ps2_led_cmd_if.sv
// Sequencer-side bundle: LED request, receiver byte stream, transmitter
// handshake and status flags.
interface ps2_led_cmd_if;
   import ps2_pkg::*;

   logic [2:0]        leds;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              tx_busy;
   logic              tx_wren;
   logic [BYTE_W-1:0] tx_d;
   logic              busy;
   logic              err;

   modport master (
      input  leds, rx_data, rx_valid, tx_busy,
      output tx_wren, tx_d, busy, err
   );

   modport slave (
      output leds, rx_data, rx_valid, tx_busy,
      input  tx_wren, tx_d, busy, err
   );

endinterface

// File: rtl/ps2_cmd_timer.sv
// Loadable down-counter that parks at zero; zero_c flags an expired wait.
module ps2_cmd_timer
   import ps2_pkg::*;
#(
   parameter int unsigned W = TIMER_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero_c
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/ps2_led_cmd.sv
// PS/2 "Set LEDs" command sequencer: sends 0xED plus the LED byte, handles
// ACK/resend/timeout and reports failure through a sticky err flag.
// Build option PS2_LED_INIT_RESET_EN adds a post-reset 0xFF/self-test pass.
module ps2_led_cmd
   import ps2_pkg::*;
#(
   parameter logic [TIMER_W-1:0] TIMEOUT   = 24'd480000,
   parameter logic [1:0]         MAX_RETRY = 2'd3
`ifdef PS2_LED_INIT_RESET_EN
   ,
   parameter logic [TIMER_W-1:0] BAT_TIMEOUT = 24'd12000000
`endif
) (
   input  logic         clk,
   input  logic         reset,
   ps2_led_cmd_if.master bus
);

`ifdef PS2_LED_INIT_RESET_EN
   localparam state_t RST_STATE = ST_SEND;
   localparam phase_t RST_PHASE = PH_RESET;
   localparam logic   RST_BUSY  = 1'b1;
`else
   localparam state_t RST_STATE = ST_IDLE;
   localparam phase_t RST_PHASE = PH_SET;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   state_t            state_q, state_d;
   phase_t            phase_q, phase_d;
   logic [1:0]        retry_q, retry_d;
   logic [2:0]        snap_q, snap_d;
   logic [2:0]        sent_q, sent_d;
   logic              err_q, err_d;
   logic              tx_wren_q, tx_wren_d;
   logic [BYTE_W-1:0] tx_d_q, tx_d_d;
   logic              busy_q, busy_d;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_dec;
   logic               tmr_zero_c;
   logic               fail;

   // Timer is loaded one short so expiry lands exactly TIMEOUT cycles after tx_wren.
   ps2_cmd_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero_c   (tmr_zero_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RST_STATE;
         phase_q   <= RST_PHASE;
         retry_q   <= 2'd0;
         snap_q    <= 3'd0;
         sent_q    <= 3'd0;
         err_q     <= 1'b0;
         tx_wren_q <= 1'b0;
         tx_d_q    <= 8'h00;
         busy_q    <= RST_BUSY;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         retry_q   <= retry_d;
         snap_q    <= snap_d;
         sent_q    <= sent_d;
         err_q     <= err_d;
         tx_wren_q <= tx_wren_d;
         tx_d_q    <= tx_d_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      retry_d   = retry_q;
      snap_d    = snap_q;
      sent_d    = sent_q;
      err_d     = err_q;
      tx_wren_d = 1'b0;
      tx_d_d    = tx_d_q;
      tmr_load  = 1'b0;
      tmr_val   = TIMEOUT - TIMER_W'(1);
      tmr_dec   = 1'b0;
      fail      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!bus.tx_busy && (bus.leds != sent_q)) begin
               snap_d  = bus.leds;
               phase_d = PH_SET;
               retry_d = 2'd0;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            tx_wren_d = 1'b1;
            tx_d_d    = cmd_byte(phase_q, snap_q);
            tmr_load  = 1'b1;
            state_d   = ST_TXSTART;
         end

         ST_TXSTART: begin
            tmr_dec = 1'b1;
            if (tmr_zero_c) begin
               fail = 1'b1;
            end else if (bus.tx_busy) begin
               state_d = ST_TXDONE;
            end
         end

         ST_TXDONE: begin
            tmr_dec = 1'b1;
            if (tmr_zero_c) begin
               fail = 1'b1;
            end else if (!bus.tx_busy) begin
               state_d = ST_WAITACK;
            end
         end

         // A received byte takes priority over a simultaneous expiry.
         ST_WAITACK: begin
            tmr_dec = 1'b1;
            if (bus.rx_valid) begin
               if (bus.rx_data == RSP_ACK) begin
                  if (phase_q == PH_SET) begin
                     phase_d = PH_LEDS;
                     retry_d = 2'd0;
                     state_d = ST_SEND;
                  end else if (phase_q == PH_LEDS) begin
                     sent_d  = snap_q;
                     err_d   = 1'b0;
                     state_d = ST_IDLE;
                  end
`ifdef PS2_LED_INIT_RESET_EN
                  else begin
                     tmr_load = 1'b1;
                     tmr_val  = BAT_TIMEOUT - TIMER_W'(1);
                     state_d  = ST_WAITBAT;
                  end
`endif
               end else if (bus.rx_data == RSP_RESEND) begin
                  if (retry_q < MAX_RETRY) begin
                     retry_d = retry_q + 2'd1;
                     state_d = ST_SEND;
                  end else begin
                     fail = 1'b1;
                  end
               end
            end else if (tmr_zero_c) begin
               fail = 1'b1;
            end
         end

`ifdef PS2_LED_INIT_RESET_EN
         ST_WAITBAT: begin
            tmr_dec = 1'b1;
            if (bus.rx_valid) begin
               if (bus.rx_data == RSP_BAT_OK) begin
                  err_d   = 1'b0;
                  state_d = ST_IDLE;
               end else if (bus.rx_data == RSP_BAT_FAIL) begin
                  fail = 1'b1;
               end
            end else if (tmr_zero_c) begin
               fail = 1'b1;
            end
         end
`endif

         default: state_d = ST_IDLE;
      endcase

      // Failure records the requested value as sent so it is not retried forever.
      if (fail) begin
         err_d   = 1'b1;
         sent_d  = snap_q;
         state_d = ST_IDLE;
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign bus.tx_wren = tx_wren_q;
   assign bus.tx_d    = tx_d_q;
   assign bus.busy    = busy_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_ps2_led_cmd.sv
// Randomized scoreboard bench for ps2_led_cmd with a transmitter/keyboard model.
module tb_ps2_led_cmd;

   localparam int TO        = 1000;
   localparam int MAXR      = 3;
   localparam int K_ACK     = 0;
   localparam int K_RESEND  = 1;
   localparam int K_NONE    = 2;
   localparam int K_ACK_BAT = 3;
   localparam int K_ACK_NOBAT = 4;
   localparam int K_BAT_AA  = 5;

   typedef struct {
      int kind;
      bit junk;
   } resp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   first_wren = -1;
   int   last_wren = 0;

   logic [7:0] exp_q[$];
   resp_t      plan[$];
   resp_t      resp_q[$];

   int    frame_left = 0;
   int    delay = -1;
   resp_t cur;

   ps2_led_cmd_if bus();

   ps2_led_cmd #(
      .TIMEOUT   (24'd1000),
      .MAX_RETRY (2'd3)
`ifdef PS2_LED_INIT_RESET_EN
      ,
      .BAT_TIMEOUT (24'd2000)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every tx_wren must match the next byte the model predicted.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset && bus.tx_wren) begin
            last_wren = cyc;
            if (first_wren < 0) first_wren = cyc;
            check("wren_while_tx_busy", 32'(bus.tx_busy), 32'd0);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL tx_unexpected: got tx_d 0x%0h, required no tx_wren", bus.tx_d);
            end else begin
               check("tx_byte", 32'(bus.tx_d), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // Transmitter (40-cycle frame) and keyboard responder driven by resp_q.
   initial begin
      bus.tx_busy  = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         bus.rx_valid = 1'b0;
         if (reset) begin
            bus.tx_busy = 1'b0;
            frame_left  = 0;
            delay       = -1;
         end else if (bus.tx_wren) begin
            bus.tx_busy = 1'b1;
            frame_left  = 40;
         end else if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) begin
               bus.tx_busy = 1'b0;
               if (resp_q.size() > 0) begin
                  cur   = resp_q.pop_front();
                  delay = 2 + int'($urandom_range(3));
               end
            end
         end else if (delay > 0) begin
            delay--;
         end else if (delay == 0) begin
            delay = -1;
            if (cur.junk) begin
               bus.rx_data  = 8'h1C;
               bus.rx_valid = 1'b1;
               cur.junk     = 1'b0;
               delay        = 2;
            end else begin
               case (cur.kind)
                  K_ACK, K_ACK_NOBAT: begin bus.rx_data = 8'hFA; bus.rx_valid = 1'b1; end
                  K_RESEND:           begin bus.rx_data = 8'hFE; bus.rx_valid = 1'b1; end
                  K_ACK_BAT: begin
                     bus.rx_data  = 8'hFA;
                     bus.rx_valid = 1'b1;
                     cur.kind     = K_BAT_AA;
                     delay        = 6;
                  end
                  K_BAT_AA:           begin bus.rx_data = 8'hAA; bus.rx_valid = 1'b1; end
                  default: ;
               endcase
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, required finish");
      $fatal(1, "watchdog");
   end

   // Reference: each send consumes one keyboard response; ACK advances,
   // silence fails, a resend beyond MAX_RETRY extra sends fails.
   task automatic model(input logic [2:0] l, output bit e_err, output bit e_to);
      logic [7:0] seq_b[2];
      int k;
      int sends;
      int kind;
      bit done;
      seq_b[0] = 8'hED;
      seq_b[1] = {5'b0, l};
      k = 0;
      e_err = 1'b0;
      e_to = 1'b0;
      for (int p = 0; p < 2; p++) begin
         if (!e_err) begin
            sends = 0;
            done = 1'b0;
            while (!done) begin
               exp_q.push_back(seq_b[p]);
               sends++;
               kind = plan[k].kind;
               k++;
               if (kind == K_ACK) done = 1'b1;
               else if (kind == K_NONE) begin e_err = 1'b1; e_to = 1'b1; done = 1'b1; end
               else if (sends > MAXR) begin e_err = 1'b1; done = 1'b1; end
            end
         end
      end
   endtask

   task automatic add_resp(input int kind, input bit junk);
      resp_t r;
      r.kind = kind;
      r.junk = junk;
      plan.push_back(r);
   endtask

   task automatic pad_plan();
      while (plan.size() < 10) add_resp(K_ACK, 1'b0);
   endtask

   task automatic wait_done(output int fall);
      int n;
      n = 0;
      while (!bus.busy && n < 10) begin @(posedge clk); #2; n++; end
      n = 0;
      while (bus.busy && n < 20000) begin @(posedge clk); #2; n++; end
      fall = cyc;
      check("seq_done_bounded", 32'(bus.busy), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.leds = 3'b000;
      repeat (3) begin @(posedge clk); #2; end
      check("rst_tx_wren", 32'(bus.tx_wren), 32'd0);
      check("rst_tx_d", 32'(bus.tx_d), 32'h00);
`ifdef PS2_LED_INIT_RESET_EN
      check("rst_busy", 32'(bus.busy), 32'd1);
`else
      check("rst_busy", 32'(bus.busy), 32'd0);
`endif
      check("rst_err", 32'(bus.err), 32'd0);
      reset = 1'b0;
   endtask

   task automatic run_txn(input logic [2:0] l, input string tag);
      bit e_err;
      bit e_to;
      int fall;
      int t0;
      pad_plan();
      exp_q.delete();
      resp_q = plan;
      model(l, e_err, e_to);
      first_wren = -1;
      t0 = cyc;
      bus.leds = l;
      wait_done(fall);
      check({tag, "_err"}, 32'(bus.err), 32'(e_err));
      check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_latency"}, 32'(first_wren - t0), 32'd2);
      if (e_to) check({tag, "_timeout_cycles"}, 32'(fall - last_wren), 32'(TO));
      exp_q.delete();
   endtask

`ifdef PS2_LED_INIT_RESET_EN
   task automatic reset_seq(input int kind, input bit e_err, input string tag);
      int fall;
      exp_q.delete();
      plan.delete();
      add_resp(kind, 1'b0);
      resp_q = plan;
      exp_q.push_back(8'hFF);
      do_reset();
      check({tag, "_busy_after_reset"}, 32'(bus.busy), 32'd1);
      wait_done(fall);
      check({tag, "_err"}, 32'(bus.err), 32'(e_err));
      check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
   endtask
`endif

   initial begin
      int fall;
      int n;
      logic [2:0] l;
      int r;
      reset = 1'b1;
      bus.leds = 3'b000;
`ifdef PS2_LED_INIT_RESET_EN
      reset_seq(K_ACK_BAT, 1'b0, "init_ok");
      reset_seq(K_ACK_NOBAT, 1'b1, "init_no_bat");
      reset_seq(K_ACK_BAT, 1'b0, "init_ok2");
`else
      do_reset();
`endif
      repeat (3) begin @(posedge clk); #2; end

      plan.delete();
      run_txn(3'b100, "d_basic");

      plan.delete();
      repeat (4) add_resp(K_RESEND, 1'b0);
      run_txn(3'b010, "d_retry_exhaust");

      plan.delete();
      add_resp(K_ACK, 1'b1);
      add_resp(K_ACK, 1'b0);
      run_txn(3'b101, "d_junk_byte");

      plan.delete();
      add_resp(K_NONE, 1'b0);
      run_txn(3'b110, "d_timeout");
      repeat (60) begin @(posedge clk); #2; end
      check("d_no_repeat_busy", 32'(bus.busy), 32'd0);

      // LED change while the LED byte is in flight: completes, then a new sequence.
      begin
         bit e1, t1, e2, t2;
         plan.delete();
         pad_plan();
         exp_q.delete();
         resp_q = plan;
         model(3'b001, e1, t1);
         model(3'b011, e2, t2);
         bus.leds = 3'b001;
         n = 0;
         while (exp_q.size() > 2 && n < 2000) begin @(posedge clk); #2; n++; end
         bus.leds = 3'b011;
         wait_done(fall);
         wait_done(fall);
         check("d_change_err", 32'(bus.err), 32'(e2));
         check("d_change_bytes_left", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end

      l = 3'b011;
      for (int t = 0; t < 20; t++) begin
         plan.delete();
         for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(99));
            add_resp((r < 65) ? K_ACK : (r < 95) ? K_RESEND : K_NONE, $urandom_range(4) == 0);
         end
         l = l ^ 3'($urandom_range(7, 1));
         run_txn(l, "rnd");
         repeat (int'($urandom_range(5))) begin @(posedge clk); #2; end
      end

      repeat (50) begin @(posedge clk); #2; end
      check("final_idle_busy", 32'(bus.busy), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_led_cmd.md
# ps2_led_cmd

Host-side command sequencer that feeds the PS/2 host-to-device transmitter. It watches the keyboard LED state requested by the core (Caps/Num/Scroll) and issues the two-byte PS/2 "Set LEDs" command: 0xED, then the LED byte. For each byte it waits for the keyboard's acknowledge, taken from the PS/2 receiver's byte stream. It handles resend requests and timeouts, and reports failure without stalling the rest of the keyboard path.

## Interface
- TIMEOUT, 24'd480000, cycles allowed from tx_wren to ACK (about 20 ms at 24 MHz)
- MAX_RETRY, 2'd3, extra sends of one byte permitted after 0xFE responses
- BAT_TIMEOUT, 24'd12000000, cycles allowed for the 0xAA self-test result (PS2_LED_INIT_RESET_EN only)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- leds  in  3  requested LEDs {caps, num, scroll}; level input, sampled in IDLE
- rx_data  in  8  byte from PS/2 receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_busy  in  1  transmitter "write" output; high while a frame is in progress
- tx_wren  out  1  one-cycle strobe to transmitter; reset 0
- tx_d  out  8  byte to send, valid with tx_wren; reset 8'h00
- busy  out  1  high whenever state != IDLE; reset 0 (without macro)
- err  out  1  sticky failure flag; set on failed sequence, cleared on next successful one; reset 0

## Operation
- Registers: state, sent_leds[2:0] (reset 0), snap_leds[2:0], phase (0 = 0xED, 1 = LED byte, 2 = 0xFF), retry[1:0], timer[23:0].
- IDLE: if tx_busy == 0 and leds != sent_leds, set snap_leds <= leds, phase <= 0, retry <= 0, and go to SEND.
- SEND: pulse tx_wren for one cycle. tx_d is 8'hED for phase 0, {5'b0, snap_leds} for phase 1, and 8'hFF for phase 2. Load timer <= TIMEOUT and go to TXSTART.
- TXSTART: wait for tx_busy == 1, then go to TXDONE.
- TXDONE: wait for tx_busy == 0, then go to WAITACK.
- Timer behaviour in TXSTART, TXDONE and WAITACK: timer decrements every cycle. On reaching 0 the sequence fails.
- WAITACK, on rx_valid with byte:
  - 0xFA: phase 0 → phase 1, retry <= 0, go to SEND. Phase 1 → sent_leds <= snap_leds, err <= 0, go to IDLE. Phase 2 → timer <= BAT_TIMEOUT, go to WAITBAT.
  - 0xFE: if retry < MAX_RETRY, then retry++ and go to SEND with the same phase. Otherwise the sequence fails.
  - any other byte: ignored, timer keeps running. Scan codes still reach the decoder through the receiver path.
- Failure: err <= 1, sent_leds <= snap_leds (no automatic re-send of the same value), go to IDLE.
- A leds change during a sequence is not applied mid-sequence. IDLE detects the difference after completion and starts a new sequence.
- Simultaneous rx_valid and timer == 0: the byte wins.

## Timing
- tx_wren occurs 2 cycles after the leds change, provided tx_busy == 0: one cycle IDLE→SEND, then the SEND cycle.
- tx_wren is never asserted while tx_busy == 1 or within the same frame. At most one tx_wren per SEND entry.
- The transmitter raises tx_busy the cycle after tx_wren. TXSTART does not depend on exact latency; the timer bounds a hang.
- An ACK is accepted in the same cycle rx_valid is seen. The next SEND follows on the next cycle.
- Reset mid-operation: all registers return to reset values on the next edge, and tx_wren is 0 in that cycle. The transmitter shares the reset.

## Configuration
- PS2_LED_INIT_RESET_EN defined:
  - After reset, state enters SEND with phase 2, so busy = 1 from the first post-reset cycle.
  - Sends 0xFF and waits for 0xFA under the TIMEOUT rule, then goes to WAITBAT.
  - WAITBAT: 0xAA → IDLE. 0xFC or timeout → failure. Other bytes are ignored.
  - sent_leds stays 0, so the LED state is pushed only on a later change.
- Undefined: the phase 2 and WAITBAT logic is absent, and reset enters IDLE.

## Structure
- Shared package ps2_pkg holds:
  - constants CMD_SET_LED = 8'hED, CMD_RESET = 8'hFF, RSP_ACK = 8'hFA, RSP_RESEND = 8'hFE, RSP_BAT_OK = 8'hAA, RSP_BAT_FAIL = 8'hFC
  - the state encoding typedef.
- One sub-module is natural: ps2_cmd_timer, a loadable 24-bit down-counter with a zero flag.

## Test plan
- leds 000→100 with a tx_busy model of 40 cycles, then FA, FA: tx_wren with 0xED, then tx_wren with 0x04; busy falls, err = 0.
- FE after 0xED, three times, with MAX_RETRY = 3: 0xED is sent 4 times. A fourth FE sets err = 1 and returns to IDLE; no 0x04 is sent.
- No response, TIMEOUT = 1000: err = 1 exactly 1000 cycles after the 0xED tx_wren, and no repeat send for the unchanged leds.
- Byte 0x1C arrives during WAITACK, then FA: 0x1C is ignored, and 0xFA advances to the LED byte.
- leds 001→011 while the second byte is in flight: 0x01 completes, then a new 0xED/0x03 sequence starts.
- Macro defined: reset releases, 0xFF is sent, then FA, AA → IDLE with err = 0. A second run with no AA and BAT_TIMEOUT = 2000 sets err = 1.
